alu_seq: RTL and testbench

Parametrised, handshaked successor to the team's 5-bit combinational ALU: same opcode encoding (add, sub, mul), plus unsigned divide, status flags and a full-width product.
Add/sub complete in one cycle. Mul and div are iterative: one bit per cycle.
Sits between an operand source and a result sink, using valid/ready on both sides.

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_iter_core.sv | 74 +++++++
 rtl/alu_seq.sv | 124 ++++++++++++
 tb/tb_alu_seq.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode encoding and handshake FSM states.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } alu_state_t;

endpackage

// File: rtl/alu_iter_core.sv
// One-bit-per-cycle datapath: unsigned shift-add multiply and restoring divide.
// res_o carries the final {hi,lo} value during the cycle last_o is high.
module alu_iter_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  alu_op_t            op_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               last_o,
  output logic [2*WIDTH-1:0] res_o
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic             busy_q;
  logic [CW-1:0]    cnt_q;
  logic             div_q;
  logic [WIDTH-1:0] hi_q, lo_q, m_q;
  logic [WIDTH-1:0] hi_d, lo_d;
  logic [WIDTH:0]   acc_w, trial_w;

  // Mul: hi accumulates, lo holds the shrinking multiplier.
  // Div: hi is the partial remainder, lo shifts dividend out and quotient in.
  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    acc_w   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    trial_w = {hi_q, lo_q[WIDTH-1]} - {1'b0, m_q};
    if (div_q) begin
      if (!trial_w[WIDTH]) begin
        hi_d = trial_w[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_d = acc_w[WIDTH:1];
      lo_d = {acc_w[0], lo_q[WIDTH-1:1]};
    end
  end

  assign last_o = busy_q && (cnt_q == '0);
  assign res_o  = {hi_d, lo_d};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      div_q  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      m_q    <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= CW'(WIDTH - 1);
      div_q  <= (op_i == OP_DIV);
      hi_q   <= '0;
      lo_q   <= (op_i == OP_DIV) ? a_i : b_i;
      m_q    <= (op_i == OP_DIV) ? b_i : a_i;
    end else if (busy_q) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      if (cnt_q == '0) busy_q <= 1'b0;
      else             cnt_q  <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: add/sub in one cycle, mul/div iterate one bit per cycle.
//   state | meaning
//   IDLE  | in_ready high, waiting for a command
//   CALC  | iterative mul/div in progress
//   DONE  | result and flags presented, out_valid high until accepted
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic [1:0]       operation,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             div_zero
);

  alu_state_t       state_q;
  alu_op_t          op_w, op_q;
  logic             accept_w, core_start_w, core_last_w;
  logic [2*WIDTH-1:0] core_res_w;
  logic [WIDTH:0]   sum_w, diff_w;
  logic             out_valid_q, carry_q, overflow_q, zero_q, div_zero_q;
  logic [WIDTH-1:0] out_q, out_hi_q;

  assign op_w         = alu_op_t'(operation);
  assign in_ready     = (state_q == IDLE) && !rst;
  assign accept_w     = in_valid && in_ready;
  assign core_start_w = accept_w && ((op_w == OP_MUL) || (op_w == OP_DIV && num2 != '0));
  assign sum_w        = {1'b0, num1} + {1'b0, num2};
  assign diff_w       = {1'b0, num1} - {1'b0, num2};

  alu_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .rst     (rst),
    .start_i (core_start_w),
    .op_i    (op_w),
    .a_i     (num1),
    .b_i     (num2),
    .last_o  (core_last_w),
    .res_o   (core_res_w)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= OP_ADD;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      out_hi_q    <= '0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      div_zero_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (accept_w) begin
          op_q <= op_w;
          unique case (op_w)
            OP_ADD, OP_SUB: begin
              out_q       <= (op_w == OP_ADD) ? sum_w[WIDTH-1:0] : diff_w[WIDTH-1:0];
              out_hi_q    <= '0;
              carry_q     <= (op_w == OP_ADD) ? sum_w[WIDTH] : diff_w[WIDTH];
              overflow_q  <= (op_w == OP_ADD)
                ? (num1[WIDTH-1] == num2[WIDTH-1]) && (sum_w[WIDTH-1] != num1[WIDTH-1])
                : (num1[WIDTH-1] != num2[WIDTH-1]) && (diff_w[WIDTH-1] != num1[WIDTH-1]);
              zero_q      <= (op_w == OP_ADD) ? (sum_w[WIDTH-1:0] == '0) : (diff_w[WIDTH-1:0] == '0);
              div_zero_q  <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
            OP_DIV: if (num2 == '0) begin
              out_q       <= '1;
              out_hi_q    <= num1;
              carry_q     <= 1'b0;
              overflow_q  <= 1'b0;
              zero_q      <= 1'b0;
              div_zero_q  <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              state_q <= CALC;
            end
            default: state_q <= CALC;
          endcase
        end
        CALC: if (core_last_w) begin
          out_q       <= core_res_w[WIDTH-1:0];
          out_hi_q    <= core_res_w[2*WIDTH-1:WIDTH];
          carry_q     <= 1'b0;
          overflow_q  <= 1'b0;
          zero_q      <= (op_q == OP_MUL) ? (core_res_w == '0) : (core_res_w[WIDTH-1:0] == '0);
          div_zero_q  <= 1'b0;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign out_hi    = out_hi_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq at WIDTH=5 with hand-computed results.
module tb_alu_seq;

  logic       clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [4:0] num1, num2, out, out_hi;
  logic [1:0] operation;
  logic       carry, overflow, zero, div_zero;
  int         checks, failures, lat;

  alu_seq #(.WIDTH(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .num1(num1), .num2(num2), .operation(operation),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .out_hi(out_hi),
    .carry(carry), .overflow(overflow), .zero(zero), .div_zero(div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one command and return cycles from accept until out_valid is seen.
  task automatic send(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b,
                      output int l);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b1; operation = op; num1 = a; num2 = b;
    @(posedge clk); #1;
    in_valid = 1'b0; num1 = 5'd27; num2 = 5'd9; operation = 2'b00;
    l = 1;
    while (!out_valid && l < 40) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic drain();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    num1 = '0; num2 = '0; operation = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if ({out, out_hi, carry, overflow, zero, div_zero} !== 14'd0) begin
      failures++; $display("FAIL rst_outputs got=%h exp=0", {out, out_hi, carry, overflow, zero, div_zero}); end
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_release_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_add();
    send(2'b00, 5'd2, 5'd2, lat);
    checks++; if (lat !== 1) begin failures++; $display("FAIL add22_latency got=%0d exp=1", lat); end
    checks++; if (out !== 5'd4 || out_hi !== 5'd0) begin failures++; $display("FAIL add22_result got=%0d/%0d exp=4/0", out, out_hi); end
    checks++; if (carry !== 1'b0 || zero !== 1'b0) begin failures++; $display("FAIL add22_flags got c=%b z=%b exp c=0 z=0", carry, zero); end
    drain();
    send(2'b00, 5'd31, 5'd1, lat);
    checks++; if (out !== 5'd0 || carry !== 1'b1 || zero !== 1'b1 || overflow !== 1'b0) begin
      failures++; $display("FAIL add31_1 got out=%0d c=%b z=%b v=%b exp out=0 c=1 z=1 v=0", out, carry, zero, overflow); end
    drain();
    send(2'b00, 5'd15, 5'd1, lat);
    checks++; if (out !== 5'd16 || overflow !== 1'b1 || carry !== 1'b0) begin
      failures++; $display("FAIL add15_1 got out=%0d v=%b c=%b exp out=16 v=1 c=0", out, overflow, carry); end
    drain();
  endtask

  task automatic test_sub();
    send(2'b01, 5'd3, 5'd1, lat);
    checks++; if (lat !== 1 || out !== 5'd2 || carry !== 1'b0) begin
      failures++; $display("FAIL sub3_1 got lat=%0d out=%0d c=%b exp lat=1 out=2 c=0", lat, out, carry); end
    drain();
    send(2'b01, 5'd1, 5'd3, lat);
    checks++; if (out !== 5'd30 || carry !== 1'b1 || overflow !== 1'b0 || out_hi !== 5'd0) begin
      failures++; $display("FAIL sub1_3 got out=%0d c=%b v=%b hi=%0d exp out=30 c=1 v=0 hi=0", out, carry, overflow, out_hi); end
    drain();
  endtask

  task automatic test_mul();
    send(2'b10, 5'd3, 5'd2, lat);
    checks++; if (lat !== 6) begin failures++; $display("FAIL mul3_2_latency got=%0d exp=6", lat); end
    checks++; if (out !== 5'd6 || out_hi !== 5'd0 || zero !== 1'b0) begin
      failures++; $display("FAIL mul3_2 got=%0d/%0d z=%b exp=6/0 z=0", out, out_hi, zero); end
    drain();
    send(2'b10, 5'd31, 5'd31, lat);
    checks++; if (out !== 5'd1 || out_hi !== 5'd30 || carry !== 1'b0) begin
      failures++; $display("FAIL mul31_31 got=%0d/%0d c=%b exp=1/30 c=0", out, out_hi, carry); end
    drain();
  endtask

  task automatic test_div();
    send(2'b11, 5'd23, 5'd5, lat);
    checks++; if (lat !== 6) begin failures++; $display("FAIL div23_5_latency got=%0d exp=6", lat); end
    checks++; if (out !== 5'd4 || out_hi !== 5'd3 || div_zero !== 1'b0) begin
      failures++; $display("FAIL div23_5 got q=%0d r=%0d dz=%b exp q=4 r=3 dz=0", out, out_hi, div_zero); end
    drain();
    send(2'b11, 5'd7, 5'd0, lat);
    checks++; if (lat !== 1) begin failures++; $display("FAIL div7_0_latency got=%0d exp=1", lat); end
    checks++; if (out !== 5'd31 || out_hi !== 5'd7 || div_zero !== 1'b1 || zero !== 1'b0) begin
      failures++; $display("FAIL div7_0 got q=%0d r=%0d dz=%b z=%b exp q=31 r=7 dz=1 z=0", out, out_hi, div_zero, zero); end
    drain();
    send(2'b11, 5'd3, 5'd7, lat);
    checks++; if (out !== 5'd0 || out_hi !== 5'd3 || zero !== 1'b1) begin
      failures++; $display("FAIL div3_7 got q=%0d r=%0d z=%b exp q=0 r=3 z=1", out, out_hi, zero); end
    drain();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(2'b10, 5'd3, 5'd2, lat);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || out !== 5'd6 || out_hi !== 5'd0 || in_ready !== 1'b0) begin
        failures++; $display("FAIL bp_hold cyc=%0d got v=%b out=%0d hi=%0d rdy=%b exp v=1 out=6 hi=0 rdy=0",
                             i, out_valid, out, out_hi, in_ready); end
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out !== 5'd6) begin
      failures++; $display("FAIL bp_release got rdy=%b v=%b out=%0d exp rdy=1 v=0 out=6", in_ready, out_valid, out); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    in_valid = 1'b1; operation = 2'b10; num1 = 5'd31; num2 = 5'd31;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b1; #1;
    checks++; if ({out, out_hi, carry, overflow, zero, div_zero, out_valid, in_ready} !== 16'd0) begin
      failures++; $display("FAIL midrst_async got=%h exp=0", {out, out_hi, carry, overflow, zero, div_zero, out_valid, in_ready}); end
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
    repeat (8) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0 || out !== 5'd0) begin
      failures++; $display("FAIL midrst_discard got v=%b out=%0d exp v=0 out=0", out_valid, out); end
    send(2'b00, 5'd2, 5'd2, lat);
    checks++; if (lat !== 1 || out !== 5'd4) begin
      failures++; $display("FAIL midrst_add22 got lat=%0d out=%0d exp lat=1 out=4", lat, out); end
    drain();
  endtask

  initial begin
    checks = 0; failures = 0;
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_div();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
